// File: rtl/key_conditioner.sv
// Push-button conditioner: per-channel 2-FF synchronizer, debounce counter and
// press/hold/repeat FSM producing a clean level plus single-cycle event pulses.
module key_conditioner #(
  parameter int N_KEYS       = 3,
  parameter int ACTIVE_LOW   = 0,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int LONG_CYC     = 25000000,
  parameter int REPEAT_CYC   = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              key_any
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DB_W-1:0]   DB_ZERO     = {DB_W{1'b0}};
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT    = {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_ZERO   = {HOLD_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [N_KEYS-1:0] key_fix_s;
  logic [N_KEYS-1:0] level_next_s;
  logic              key_any_r;

  assign key_fix_s = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic              s1_r, s2_r;
    logic              level_r, press_r, release_r, repeat_r;
    logic              level_s, press_s, release_s, repeat_s, accept_s;
    logic [DB_W-1:0]   db_cnt_r, db_cnt_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s, hold_inc_s;
    state_t            state_r, state_s;

    // Synchronizer, counters, FSM state and registered outputs for this channel
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_r       <= 1'b0;
        s2_r       <= 1'b0;
        db_cnt_r   <= DB_ZERO;
        hold_cnt_r <= HOLD_ZERO;
        state_r    <= ST_IDLE;
        level_r    <= 1'b0;
        press_r    <= 1'b0;
        release_r  <= 1'b0;
        repeat_r   <= 1'b0;
      end else begin
        s1_r       <= key_fix_s[i];
        s2_r       <= s1_r;
        db_cnt_r   <= db_cnt_s;
        hold_cnt_r <= hold_cnt_s;
        state_r    <= state_s;
        level_r    <= level_s;
        press_r    <= press_s;
        release_r  <= release_s;
        repeat_r   <= repeat_s;
      end
    end

    // Debounce acceptance and press/hold/repeat next-state logic
    always_comb begin
      db_cnt_s   = db_cnt_r;
      accept_s   = 1'b0;
      hold_inc_s = hold_cnt_r;
      hold_cnt_s = hold_cnt_r;
      state_s    = state_r;
      level_s    = level_r;
      press_s    = 1'b0;
      release_s  = 1'b0;
      repeat_s   = 1'b0;

      if (s2_r == level_r) begin
        db_cnt_s = DB_ZERO;
      end else if (db_cnt_r == DB_LAST) begin
        db_cnt_s = DB_ZERO;
        accept_s = 1'b1;
      end else begin
        db_cnt_s = db_cnt_r + DB_W'(1);
      end

      if (hold_cnt_r == HOLD_SAT) begin
        hold_inc_s = hold_cnt_r;
      end else begin
        hold_inc_s = hold_cnt_r + HOLD_W'(1);
      end

      // A release accepted on a repeat edge takes priority over the repeat
      case (state_r)
        ST_IDLE: begin
          hold_cnt_s = HOLD_ZERO;
          if (accept_s) begin
            state_s = ST_HELD;
            level_s = 1'b1;
            press_s = 1'b1;
          end else begin
            level_s = 1'b0;
          end
        end
        ST_HELD: begin
          if (accept_s) begin
            state_s    = ST_IDLE;
            level_s    = 1'b0;
            release_s  = 1'b1;
            hold_cnt_s = HOLD_ZERO;
          end else if (hold_cnt_r == LONG_LAST) begin
            state_s    = ST_REPEAT;
            repeat_s   = 1'b1;
            hold_cnt_s = HOLD_ZERO;
          end else begin
            hold_cnt_s = hold_inc_s;
          end
        end
        ST_REPEAT: begin
          if (accept_s) begin
            state_s    = ST_IDLE;
            level_s    = 1'b0;
            release_s  = 1'b1;
            hold_cnt_s = HOLD_ZERO;
          end else if (hold_cnt_r == REPEAT_LAST) begin
            repeat_s   = 1'b1;
            hold_cnt_s = HOLD_ZERO;
          end else begin
            hold_cnt_s = hold_inc_s;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          level_s    = 1'b0;
          hold_cnt_s = HOLD_ZERO;
        end
      endcase
    end

    assign key_level[i]    = level_r;
    assign key_press[i]    = press_r;
    assign key_release[i]  = release_r;
    assign key_repeat[i]   = repeat_r;
    assign level_next_s[i] = level_s;
  end

  // key_any registered from next-state levels so it lines up with key_level
  always_ff @(posedge clk) begin
    if (rst) begin
      key_any_r <= 1'b0;
    end else begin
      key_any_r <= |level_next_s;
    end
  end

  assign key_any = key_any_r;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed self-checking bench for key_conditioner with short debounce/hold
// timings; every step compares all outputs against hand-derived values.
module tb_key_conditioner;

  logic       clk;
  logic       rst;
  logic [2:0] key_raw;
  logic [2:0] key_level, key_press, key_release, key_repeat;
  logic       key_any;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] bounce_pat;

  key_conditioner #(
    .N_KEYS      (3),
    .ACTIVE_LOW  (0),
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (10),
    .REPEAT_CYC  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat),
    .key_any    (key_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, then compare every output 1 time unit later.
  task automatic cyc(input string tag, input logic [2:0] lvl, input logic [2:0] prs,
                     input logic [2:0] rel, input logic [2:0] rep);
    logic [12:0] obs;
    logic [12:0] exp;
    @(posedge clk);
    #1;
    obs = {key_level, key_press, key_release, key_repeat, key_any};
    exp = {lvl, prs, rel, rep, |lvl};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed lvl/prs/rel/rep/any=%b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) cyc(tag, 3'b000, 3'b000, 3'b000, 3'b000);
  endtask

  initial begin
    rst        = 1'b1;
    key_raw    = 3'b111;
    bounce_pat = 10'b1111110111;

    // Reset with all keys held: outputs stay 0, then a normal press appears
    for (int k = 0; k < 5; k++) cyc("reset_hold", 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) cyc("reset_fill", 3'b000, 3'b000, 3'b000, 3'b000);
    cyc("reset_press", 3'b111, 3'b111, 3'b000, 3'b000);
    cyc("reset_post", 3'b111, 3'b000, 3'b000, 3'b000);
    key_raw = 3'b000;
    for (int k = 0; k < 5; k++) cyc("reset_rel_wait", 3'b111, 3'b000, 3'b000, 3'b000);
    cyc("reset_release", 3'b000, 3'b000, 3'b111, 3'b000);
    idle("reset_idle", 3);

    // Clean press / release on key0
    key_raw = 3'b001;
    idle("k0_fill", 5);
    cyc("k0_press", 3'b001, 3'b001, 3'b000, 3'b000);
    for (int k = 0; k < 2; k++) cyc("k0_hold", 3'b001, 3'b000, 3'b000, 3'b000);
    key_raw = 3'b000;
    for (int k = 0; k < 5; k++) cyc("k0_rel_wait", 3'b001, 3'b000, 3'b000, 3'b000);
    cyc("k0_release", 3'b000, 3'b000, 3'b001, 3'b000);
    idle("k0_idle", 3);

    // Bounce on key1: one press 6 edges after the final rise
    for (int i = 0; i < 10; i++) begin
      key_raw[1] = bounce_pat[i];
      cyc("k1_bounce", (i == 9) ? 3'b010 : 3'b000, (i == 9) ? 3'b010 : 3'b000,
          3'b000, 3'b000);
    end
    key_raw = 3'b000;
    for (int k = 0; k < 5; k++) cyc("k1_rel_wait", 3'b010, 3'b000, 3'b000, 3'b000);
    cyc("k1_release", 3'b000, 3'b000, 3'b010, 3'b000);
    idle("k1_idle", 3);
    key_raw = 3'b010;
    idle("k1_short_pulse", 3);
    key_raw = 3'b000;
    idle("k1_short_after", 8);

    // Auto-repeat on key2, released after 30 held cycles
    key_raw = 3'b100;
    idle("k2_fill", 5);
    cyc("k2_press", 3'b100, 3'b100, 3'b000, 3'b000);
    for (int t = 1; t <= 36; t++) begin
      if (t == 31) key_raw = 3'b000;
      cyc("k2_repeat", (t < 36) ? 3'b100 : 3'b000, 3'b000,
          (t == 36) ? 3'b100 : 3'b000,
          (t >= 10 && t < 36 && ((t - 10) % 3) == 0) ? 3'b100 : 3'b000);
    end
    idle("k2_idle", 3);

    // Release accepted on the same edge a repeat would fire
    key_raw = 3'b100;
    idle("k2b_fill", 5);
    cyc("k2b_press", 3'b100, 3'b100, 3'b000, 3'b000);
    for (int t = 1; t <= 16; t++) begin
      if (t == 11) key_raw = 3'b000;
      cyc("k2b_collide", (t < 16) ? 3'b100 : 3'b000, 3'b000,
          (t == 16) ? 3'b100 : 3'b000,
          (t == 10 || t == 13) ? 3'b100 : 3'b000);
    end
    idle("k2b_idle", 4);

    // Independence: key0 and key1 pressed two edges apart, released separately
    key_raw = 3'b001;
    for (int t = 1; t <= 16; t++) begin
      if (t == 3)  key_raw[1] = 1'b1;
      if (t == 9)  key_raw[0] = 1'b0;
      if (t == 11) key_raw[1] = 1'b0;
      cyc("indep", {1'b0, (t >= 8 && t < 16), (t >= 6 && t < 14)},
          {1'b0, (t == 8), (t == 6)},
          {1'b0, (t == 16), (t == 14)},
          3'b000);
    end
    idle("indep_idle", 3);

    // Reset while key0 is in auto-repeat, key kept held through it
    key_raw = 3'b001;
    for (int t = 1; t <= 17; t++) begin
      cyc("midhold", {2'b00, (t >= 6)}, {2'b00, (t == 6)}, 3'b000,
          {2'b00, (t == 16)});
    end
    rst = 1'b1;
    idle("midhold_rst", 2);
    rst = 1'b0;
    idle("midhold_refill", 5);
    cyc("midhold_repress", 3'b001, 3'b001, 3'b000, 3'b000);
    cyc("midhold_held", 3'b001, 3'b000, 3'b000, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
